// File: rtl/ovl_fire_logger.sv
// ovl_fire_logger
//   Collects the per-checker OVL `out` bits into a masked fire vector. It keeps
//   sticky per-checker status and queues {timestamp, fire vector} records in a
//   first-word-fall-through FIFO for the readout host.
//
// Ports
//   clk       : clock
//   rst       : synchronous, active-low reset
//   enable    : logging enable (IDLE <-> RUN)
//   fire_in   : checker fire bits
//   chk_mask  : 1 = ignore that checker
//   clear     : pulse; clears sticky/ovf/drop_cnt and leaves FROZEN
//   rd_en     : pop the head record (ignored while empty)
//   rd_valid  : FIFO non-empty
//   rd_data   : head record {ts, fire_vec}, or 0 while empty
//   full      : FIFO full
//   sticky    : per-checker "has fired" bits
//   ovf       : sticky "a record was dropped"
//   drop_cnt  : dropped records, saturating at 255
//   irq       : registered rd_valid | ovf
//
// Build option
//   OVL_FIRE_EDGE_EN : capture only on rising edges of fire_in (one record per
//                      assertion) instead of on every cycle the fire is held.
module ovl_fire_logger #(
  parameter int NUM_CHK     = 8,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 8,
  parameter bit STOP_ON_OVF = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CHK-1:0]      fire_in,
  input  logic [NUM_CHK-1:0]      chk_mask,
  input  logic                    clear,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [TS_W+NUM_CHK-1:0] rd_data,
  output logic                    full,
  output logic [NUM_CHK-1:0]      sticky,
  output logic                    ovf,
  output logic [7:0]              drop_cnt,
  output logic                    irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + NUM_CHK;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF))
      return v + 8'd1;
    return v;
  endfunction

  state_t              state, state_nxt;
  logic                cap_en;
  logic [TS_W-1:0]     ts;
  logic [NUM_CHK-1:0]  fv_p0;
  logic                vld_p0;
  logic                pop, drop, wr;
  logic [RW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, count_nxt;
  logic [NUM_CHK-1:0]  sticky_nxt;
  logic                ovf_nxt;
  logic [7:0]          drop_cnt_nxt;

  // ---- stage p0: masked fire vector and capture request ----
`ifdef OVL_FIRE_EDGE_EN
  logic [NUM_CHK-1:0] fire_q;

  always_ff @(posedge clk) begin
    if (!rst)
      fire_q <= '0;
    else
      fire_q <= fire_in;
  end

  assign fv_p0 = fire_in & ~fire_q & ~chk_mask;
`else
  assign fv_p0 = fire_in & ~chk_mask;
`endif

  assign vld_p0 = cap_en && (fv_p0 != '0);

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable)
          state_nxt = IDLE;
        else if (STOP_ON_OVF && drop)
          state_nxt = FROZEN;
      end
      FROZEN: begin
        if (clear)
          state_nxt = enable ? RUN : IDLE;
        else if (!enable)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_en = 1'b0;
    unique case (state)
      RUN:     cap_en = 1'b1;
      default: cap_en = 1'b0;
    endcase
  end

  // ---- stage p1: FIFO push/pop and status ----
  assign rd_valid  = (count != '0);
  assign full      = (count == DEPTH_CNT);
  assign pop       = rd_en & rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO only drops when no pop.
  assign drop      = vld_p0 & full & ~pop;
  assign wr        = vld_p0 & ~drop;
  assign count_nxt = count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
  // Empty FIFO presents zero rather than a stale entry.
  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

  // clear acts before this cycle's fire/drop so both survive the clear.
  assign sticky_nxt   = (clear ? '0 : sticky) | fv_p0;
  assign ovf_nxt      = (clear ? 1'b0 : ovf) | drop;
  assign drop_cnt_nxt = sat_inc(clear ? 8'd0 : drop_cnt, drop);

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {ts, fv_p0};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      sticky   <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (cap_en)
        ts <= ts + TS_W'(1);
      sticky   <= sticky_nxt;
      ovf      <= ovf_nxt;
      drop_cnt <= drop_cnt_nxt;
      irq      <= (count_nxt != '0) | ovf_nxt;
    end
  end

endmodule

// File: tb/tb_ovl_fire_logger.sv
// Testbench for ovl_fire_logger: table of directed vectors, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_ovl_fire_logger;

  localparam int NUM_CHK = 8;
  localparam int TS_W    = 16;
  localparam int DEPTH   = 8;
  localparam int RW      = TS_W + NUM_CHK;
`ifdef OVL_FIRE_EDGE_EN
  localparam int HOLD5_RECS = 1;
`else
  localparam int HOLD5_RECS = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, clear, rd_en;
  logic [7:0]    fire_in, chk_mask;

  logic          rd_valid, full, ovf, irq;
  logic [RW-1:0] rd_data;
  logic [7:0]    sticky, drop_cnt;

  logic          s_rd_valid, s_full, s_ovf, s_irq;
  logic [RW-1:0] s_rd_data;
  logic [7:0]    s_sticky, s_drop_cnt;

  ovl_fire_logger #(.NUM_CHK(NUM_CHK), .TS_W(TS_W), .DEPTH(DEPTH), .STOP_ON_OVF(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fire_in(fire_in), .chk_mask(chk_mask),
    .clear(clear), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .full(full),
    .sticky(sticky), .ovf(ovf), .drop_cnt(drop_cnt), .irq(irq)
  );

  ovl_fire_logger #(.NUM_CHK(NUM_CHK), .TS_W(TS_W), .DEPTH(DEPTH), .STOP_ON_OVF(1'b1)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .fire_in(fire_in), .chk_mask(chk_mask),
    .clear(clear), .rd_en(rd_en), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .full(s_full),
    .sticky(s_sticky), .ovf(s_ovf), .drop_cnt(s_drop_cnt), .irq(s_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (non-stopping instance) ----------------
  logic [RW-1:0] mq[$];
  bit            m_run;
  int            m_ts;
  logic [7:0]    m_sticky, m_fq;
  bit            m_ovf;
  int            m_drop;

  function automatic void model_step();
    logic [7:0] fv;
    bit pop, push, drop;
    fv = fire_in & ~chk_mask;
`ifdef OVL_FIRE_EDGE_EN
    fv = fv & ~m_fq;
`endif
    if (!rst) begin
      mq.delete();
      m_run = 0; m_ts = 0; m_sticky = '0; m_fq = '0; m_ovf = 0; m_drop = 0;
      return;
    end
    pop  = rd_en && (mq.size() > 0);
    push = m_run && (fv != 0);
    drop = push && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !drop) mq.push_back({16'(m_ts), fv});
    if (clear) begin m_sticky = '0; m_ovf = 0; m_drop = 0; end
    m_sticky = m_sticky | fv;
    if (drop) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    if (m_run) m_ts = (m_ts + 1) % (1 << TS_W);
    m_run = enable;
    m_fq  = fire_in;
  endfunction

  function automatic void check_all();
    check("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    check("rd_data",  64'(rd_data),  (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    check("full",     64'(full),     64'(mq.size() == DEPTH));
    check("sticky",   64'(sticky),   64'(m_sticky));
    check("ovf",      64'(ovf),      64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("irq",      64'(irq),      64'((mq.size() != 0) || m_ovf));
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input logic r, input logic en, input logic [7:0] f,
                        input logic [7:0] m, input logic c, input logic rd);
    rst = r; enable = en; fire_in = f; chk_mask = m; clear = c; rd_en = rd;
  endtask

  function automatic logic [7:0] alt(input int k);
    return (k % 2) ? 8'h02 : 8'h01;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r, en;
    logic [7:0]    fire, mask;
    logic          clr, rd;
    logic          vld;
    logic [RW-1:0] data;
    logic [7:0]    stk;
    logic          irq;
  } vec_t;

  function automatic vec_t mk(logic r, logic en, logic [7:0] f, logic [7:0] m, logic c,
                              logic rd, logic v, logic [RW-1:0] d, logic [7:0] s, logic i);
    vec_t x;
    x.r = r; x.en = en; x.fire = f; x.mask = m; x.clr = c; x.rd = rd;
    x.vld = v; x.data = d; x.stk = s; x.irq = i;
    return x;
  endfunction

  vec_t tbl[13];

  initial begin
    int cnt;
    logic [RW-1:0] exp_rec;
    int t;

    set_in(0, 0, 8'h00, 8'h00, 0, 0);

    tbl[0]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[1]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[2]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[3]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[4]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[5]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[6]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[7]  = mk(1, 1, 8'h04, 8'h00, 0, 0, 1, 24'h000504, 8'h04, 1);
    tbl[8]  = mk(1, 1, 8'h00, 8'h00, 0, 1, 0, 24'h0,      8'h04, 0);
    tbl[9]  = mk(1, 1, 8'h00, 8'h00, 1, 0, 0, 24'h0,      8'h00, 0);
    tbl[10] = mk(1, 1, 8'h01, 8'h01, 0, 0, 0, 24'h0,      8'h00, 0);
    tbl[11] = mk(1, 1, 8'h03, 8'h01, 0, 0, 1, 24'h000902, 8'h02, 1);
    tbl[12] = mk(1, 1, 8'h00, 8'h01, 0, 1, 0, 24'h0,      8'h02, 0);

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].r, tbl[i].en, tbl[i].fire, tbl[i].mask, tbl[i].clr, tbl[i].rd);
      cycle();
      check($sformatf("tbl%0d_vld", i),  64'(rd_valid), 64'(tbl[i].vld));
      check($sformatf("tbl%0d_data", i), 64'(rd_data),  64'(tbl[i].data));
      check($sformatf("tbl%0d_stk", i),  64'(sticky),   64'(tbl[i].stk));
      check($sformatf("tbl%0d_irq", i),  64'(irq),      64'(tbl[i].irq));
    end

    // Overflow: 10 firing cycles into 8 slots, then fire+pop while full.
    set_in(0, 0, 8'h00, 8'h00, 0, 0); cycle();
    set_in(1, 1, 8'h00, 8'h00, 0, 0); cycle();
    for (int k = 0; k < 10; k++) begin
      set_in(1, 1, alt(k), 8'h00, 0, 0); cycle();
    end
    check("ovfl_full", 64'(full), 64'd1);
    check("ovfl_drop", 64'(drop_cnt), 64'd2);
    check("ovfl_ovf", 64'(ovf), 64'd1);
    set_in(1, 1, 8'h01, 8'h00, 0, 1); cycle();
    check("fullpop_full", 64'(full), 64'd1);
    check("fullpop_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 8; i++) begin
      t = (i < 7) ? i + 1 : 10;
      exp_rec = {16'(t), (i < 7) ? alt(t) : 8'h01};
      check($sformatf("drain%0d", i), 64'(rd_data), 64'(exp_rec));
      set_in(1, 0, 8'h00, 8'h00, 0, 1); cycle();
    end
    check("drain_empty", 64'(rd_valid), 64'd0);

    // STOP_ON_OVF instance: freeze on the first drop, resume after clear.
    set_in(0, 0, 8'h00, 8'h00, 0, 0); cycle();
    set_in(1, 1, 8'h00, 8'h00, 0, 0); cycle();
    for (int k = 0; k < 9; k++) begin
      set_in(1, 1, alt(k), 8'h00, 0, 0); cycle();
    end
    check("stop_drop", 64'(s_drop_cnt), 64'd1);
    check("stop_ovf", 64'(s_ovf), 64'd1);
    check("stop_full", 64'(s_full), 64'd1);
    for (int k = 9; k < 12; k++) begin
      set_in(1, 1, alt(k), 8'h00, 0, 0); cycle();
    end
    check("frozen_drop", 64'(s_drop_cnt), 64'd1);
    set_in(1, 1, 8'h00, 8'h00, 1, 0); cycle();
    check("frz_clr_ovf", 64'(s_ovf), 64'd0);
    check("frz_clr_drop", 64'(s_drop_cnt), 64'd0);
    set_in(1, 1, 8'h00, 8'h00, 0, 1); cycle();
    set_in(1, 1, 8'h04, 8'h00, 0, 0); cycle();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("stop_rd%0d", i), 64'(s_rd_data[RW-1:8]), 64'(i + 1));
      set_in(1, 0, 8'h00, 8'h00, 0, 1); cycle();
    end
    check("stop_resume", 64'(s_rd_data), 64'({16'd10, 8'h04}));

    // Reset with records pending.
    set_in(0, 0, 8'h00, 8'h00, 0, 0); cycle();
    set_in(1, 1, 8'h00, 8'h00, 0, 0); cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, alt(k), 8'h00, 0, 0); cycle();
    end
    check("pre_rst_vld", 64'(rd_valid), 64'd1);
    set_in(0, 1, 8'h00, 8'h00, 0, 0); cycle();
    check("rst_vld", 64'(rd_valid), 64'd0);
    check("rst_stk", 64'(sticky), 64'd0);
    set_in(1, 1, 8'h00, 8'h00, 0, 0); cycle();
    set_in(1, 1, 8'h08, 8'h00, 0, 0); cycle();
    check("rst_ts0", 64'(rd_data), 64'({16'd0, 8'h08}));

    // Fire held for 5 cycles.
    set_in(0, 0, 8'h00, 8'h00, 0, 0); cycle();
    set_in(1, 1, 8'h00, 8'h00, 0, 0); cycle();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 1, 8'h10, 8'h00, 0, 0); cycle();
    end
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (rd_valid) cnt++;
      set_in(1, 0, 8'h00, 8'h00, 0, 1); cycle();
    end
    check("hold5_records", 64'(cnt), 64'(HOLD5_RECS));

    // drop_cnt saturation, then clear coinciding with fire and a drop.
    set_in(0, 0, 8'h00, 8'h00, 0, 0); cycle();
    set_in(1, 1, 8'h00, 8'h00, 0, 0); cycle();
    for (int k = 0; k < 270; k++) begin
      set_in(1, 1, alt(k), 8'h00, 0, 0); cycle();
    end
    check("sat_drop", 64'(drop_cnt), 64'd255);
    set_in(1, 1, 8'h01, 8'h00, 1, 0); cycle();
    check("clrfire_stk", 64'(sticky), 64'h01);
    check("clrfire_ovf", 64'(ovf), 64'd1);
    check("clrfire_drop", 64'(drop_cnt), 64'd1);
    check("clrfire_full", 64'(full), 64'd1);

    // Randomized traffic, model-checked every cycle.
    set_in(0, 0, 8'h00, 8'h00, 0, 0); cycle();
    for (int n = 0; n < 3000; n++) begin
      bit slow_rd;
      slow_rd = ((n / 300) % 2) == 0;
      set_in(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
             ($urandom_range(0, 59) == 0),
             slow_rd ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ovl_fire_logger.md
Name: ovl_fire_logger

Overview:
- Downstream consumer of the wrapped OVL checkers; collects the per-checker `out` bits into a fire vector.
- Captures sticky per-checker status and timestamps every firing cycle.
- Buffers {timestamp, fire vector} records in a first-word-fall-through FIFO for the fabric readout/debug host.
- Raises an interrupt when unread records exist or when records are dropped.

Parameters:
- NUM_CHK, 8: number of checker fire inputs.
- TS_W, 16: timestamp counter width.
- DEPTH, 8: FIFO entries; must be a power of 2, >= 2.
- STOP_ON_OVF, 0: 1 = enter FROZEN on the first dropped record.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  logging enable.
- fire_in  in  NUM_CHK  checker `out` bits; already gated by prevConfigInvalid upstream.
- chk_mask  in  NUM_CHK  1 = ignore that checker.
- clear  in  1  single-cycle pulse; clears sticky, ovf, drop_cnt, and leaves FROZEN.
- rd_en  in  1  pop the head record.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  TS_W+NUM_CHK  head record, {ts, fire_vec}; fire_vec in the LSBs.
- full  out  1  FIFO full.
- sticky  out  NUM_CHK  per-checker "has fired" bits.
- ovf  out  1  sticky: a record was dropped.
- drop_cnt  out  8  dropped records, saturating at 255.
- irq  out  1  rd_valid | ovf, registered.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM=IDLE; ts=0; FIFO empty, so rd_valid=0 and full=0.
  - sticky=0, ovf=0, drop_cnt=0, irq=0; rd_data=0.
  - Applies mid-operation too: pending records are discarded.
- Masked vector: fv = fire_in & ~chk_mask. A cycle "fires" when fv != 0.
- FSM:
  - IDLE: no capture; ts held. Go to RUN when enable=1.
  - RUN: ts increments every cycle and wraps 2^TS_W-1 -> 0. Go to IDLE when enable=0. Go to FROZEN on a drop when STOP_ON_OVF=1.
  - FROZEN: no capture; ts held; sticky still updates. Leave on clear -> RUN if enable=1, else IDLE. enable=0 -> IDLE, but ovf stays set.
- Capture (RUN only):
  - A firing cycle pushes {ts_current, fv}, where ts_current is the value before that cycle's increment.
  - The record is visible at rd_data one cycle after the firing cycle (latency 1).
  - A fire held for k cycles produces k records.
- Sticky: sticky |= fv every cycle in any non-reset state, including IDLE.
- FIFO:
  - FWFT: rd_data is valid whenever rd_valid=1.
  - A pop occurs on rd_en & rd_valid; rd_en while empty is ignored and causes no underflow.
  - Push with full=1 and no pop in the same cycle: record dropped; ovf<=1; drop_cnt+1 (saturating).
  - Push with full=1 and a pop in the same cycle: both succeed; no drop; full stays 1.
  - Simultaneous push/pop when empty: the push is accepted; no bypass, so rd_valid rises next cycle.
  - Pointers wrap modulo DEPTH; occupancy counter has log2(DEPTH)+1 bits.
- clear and fire in the same cycle:
  - clear applies first, then the new fire, so sticky=fv.
  - A drop in that same cycle sets ovf=1 and drop_cnt=1.
  - FIFO contents are unaffected by clear.
- irq is registered from next-state values.

Optional Feature:
- Macro OVL_FIRE_EDGE_EN.
- Defined:
  - fv = fire_in & ~fire_q & ~chk_mask, where fire_q is the previous-cycle fire_in (reset 0; updated in all states).
  - A fire held for k cycles produces one record, on its rising edge only.
- Undefined: level capture as above; no fire_q register.

Test Plan:
- Reset then enable=1; fire_in=8'h04 at ts=5 for 1 cycle -> next cycle rd_valid=1, rd_data={16'd5, 8'h04}; sticky=8'h04; irq=1; rd_en pops -> rd_valid=0.
- chk_mask=8'h01, fire_in=8'h01 -> no record, sticky=0. Then fire_in=8'h03 -> record with fv=8'h02.
- DEPTH=8, 10 consecutive firing cycles with no reads -> full=1, drop_cnt=2, ovf=1. Reading out gives ts values 0..7 in order.
- Full FIFO, fire and rd_en in the same cycle -> no drop, full stays 1, the new record lands at the tail.
- STOP_ON_OVF=1; overflow -> FROZEN, ts freezes. clear with enable=1 -> RUN, ovf=0, drop_cnt=0, ts resumes.
- rst=0 asserted with 3 records queued -> next cycle rd_valid=0, sticky=0, ts=0.
- OVL_FIRE_EDGE_EN: fire_in=8'h10 held 5 cycles -> exactly one record. Without the macro -> five records.
